// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions for the register-file write-back path.
`default_nettype none

package mips_pkg;

   localparam int REG_AW = 5;
   localparam int XLEN   = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fwd_match.sv
// Youngest-match search of pending write-back entries for one lookup address.
`default_nettype none

module wb_fwd_match
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  wb_entry_t         entries [DEPTH],
   input  logic [DEPTH-1:0]  valid,
   input  logic [PW-1:0]     head,
   input  logic [REG_AW-1:0] addr,
   output logic              hit,
   output logic [XLEN-1:0]   data
);

   logic [PW-1:0] idx;

   // Walk oldest to youngest so later matches overwrite earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (valid[idx] && (entries[idx].addr == addr) && (addr != REG_ZERO)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue merging ALU and MDU writes onto the register file's
// single write port, with forwarding of pending values to the decode read ports.
`default_nettype none

module regfile_wb_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_AW,
   parameter int DW    = XLEN
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_we,
   input  logic [AW-1:0]            alu_a,
   input  logic [DW-1:0]            alu_wd,
   input  logic                     mdu_valid,
   input  logic [AW-1:0]            mdu_a,
   input  logic [DW-1:0]            mdu_wd,
   output logic                     mdu_ready,
   output logic                     rf_we3,
   output logic [AW-1:0]            rf_a3,
   output logic [DW-1:0]            rf_wd3,
   input  logic [AW-1:0]            q_a1,
   input  logic [AW-1:0]            q_a2,
   output logic                     fwd_hit1,
   output logic                     fwd_hit2,
   output logic [DW-1:0]            fwd_d1,
   output logic [DW-1:0]            fwd_d2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t        entries [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count_q;
   logic             nonempty;
   logic             alu_enq;
   logic             mdu_enq;
   logic [CW-1:0]    free;
   logic [PW-1:0]    mdu_slot;
   logic [DEPTH-1:0] valid;

   assign nonempty  = (count_q != '0);
   assign alu_enq   = alu_we && (alu_a != REG_ZERO);
   // The head slot is released by this cycle's drain, so it is reusable now.
   assign free      = CW'(DEPTH) - count_q + CW'(nonempty);
   assign mdu_ready = (free >= (CW'(1) + CW'(alu_enq)));
   assign mdu_enq   = mdu_valid && mdu_ready && (mdu_a != REG_ZERO);
   assign mdu_slot  = tail + PW'(alu_enq);

   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         head    <= head + PW'(nonempty);
         tail    <= tail + PW'(alu_enq) + PW'(mdu_enq);
         count_q <= count_q + CW'(alu_enq) + CW'(mdu_enq) - CW'(nonempty);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && alu_enq) begin
         entries[tail] <= '{addr: alu_a, data: alu_wd};
      end
      if (!reset && mdu_enq) begin
         entries[mdu_slot] <= '{addr: mdu_a, data: mdu_wd};
      end
   end

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_valid
         logic [PW-1:0] age;
         assign age      = PW'(i) - head;
         assign valid[i] = ({1'b0, age} < count_q);
      end
   endgenerate

   assign rf_we3 = nonempty;
   assign rf_a3  = nonempty ? entries[head].addr : '0;
   assign rf_wd3 = nonempty ? entries[head].data : '0;
   assign count  = count_q;

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .entries (entries),
      .valid   (valid),
      .head    (head),
      .addr    (q_a1),
      .hit     (fwd_hit1),
      .data    (fwd_d1)
   );

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .entries (entries),
      .valid   (valid),
      .head    (head),
      .addr    (q_a2),
      .hit     (fwd_hit2),
      .data    (fwd_d2)
   );

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue against a queue-based reference model.
`default_nettype none

module tb_regfile_wb_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        alu_we;
   logic [4:0]  alu_a;
   logic [31:0] alu_wd;
   logic        mdu_valid;
   logic [4:0]  mdu_a;
   logic [31:0] mdu_wd;
   logic        mdu_ready;
   logic        rf_we3;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd3;
   logic [4:0]  q_a1;
   logic [4:0]  q_a2;
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [31:0] fwd_d1;
   logic [31:0] fwd_d2;
   logic [2:0]  count;

   regfile_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_we    (alu_we),
      .alu_a     (alu_a),
      .alu_wd    (alu_wd),
      .mdu_valid (mdu_valid),
      .mdu_a     (mdu_a),
      .mdu_wd    (mdu_wd),
      .mdu_ready (mdu_ready),
      .rf_we3    (rf_we3),
      .rf_a3     (rf_a3),
      .rf_wd3    (rf_wd3),
      .q_a1      (q_a1),
      .q_a2      (q_a2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_d1    (fwd_d1),
      .fwd_d2    (fwd_d2),
      .count     (count)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];   // pending writes as the model sees them
   ent_t sb[$];   // expected drain order, consumed by the monitor
   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
      if (a != 5'd0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == a) begin
               h = 1'b1;
               d = mq[i].d;
               break;
            end
         end
      end
   endfunction

   task automatic step(input logic r, input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] x1, input logic [4:0] x2);
      int          n;
      logic        ne, aenq, rdy, h;
      logic [31:0] d;
      ent_t        e;
      @(negedge clk);
      reset = r; alu_we = aw; alu_a = aa; alu_wd = ad;
      mdu_valid = mv; mdu_a = ma; mdu_wd = md; q_a1 = x1; q_a2 = x2;
      #1;
      n    = mq.size();
      ne   = (n != 0);
      aenq = aw && (aa != 5'd0);
      rdy  = ((DEPTH - n + int'(ne)) >= (1 + int'(aenq)));
      chk("count", 32'(count), 32'(n));
      chk("mdu_ready", 32'(mdu_ready), 32'(rdy));
      chk("rf_we3", 32'(rf_we3), 32'(ne));
      if (!ne) begin
         chk("rf_a3_empty", 32'(rf_a3), 32'd0);
         chk("rf_wd3_empty", rf_wd3, 32'd0);
      end
      lookup(x1, h, d);
      chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
      chk("fwd_d1", fwd_d1, d);
      lookup(x2, h, d);
      chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
      chk("fwd_d2", fwd_d2, d);
      @(posedge clk);
      if (r) begin
         mq.delete();
         sb.delete();
      end else begin
         if (ne) void'(mq.pop_front());
         if (aenq) begin
            e.a = aa; e.d = ad;
            mq.push_back(e); sb.push_back(e);
         end
         if (mv && rdy && (ma != 5'd0)) begin
            e.a = ma; e.d = md;
            mq.push_back(e); sb.push_back(e);
         end
      end
   endtask

   task automatic idle(input logic [4:0] x1, input logic [4:0] x2);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x1, x2);
   endtask

   // Drain monitor: every presented write must be the next accepted one.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #3;
         if (rf_we3 === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL drain_extra: got a3=%0d wd3=%h expected no write", rf_a3, rf_wd3);
            end else begin
               e = sb.pop_front();
               if (rf_a3 !== e.a || rf_wd3 !== e.d) begin
                  n_errors++;
                  $display("FAIL drain_order: got a3=%0d wd3=%h expected a3=%0d wd3=%h",
                           rf_a3, rf_wd3, e.a, e.d);
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1; alu_we = 1'b0; alu_a = '0; alu_wd = '0;
      mdu_valid = 1'b0; mdu_a = '0; mdu_wd = '0; q_a1 = '0; q_a2 = '0;
      repeat (2) @(posedge clk);

      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      idle(5'd3, 5'd5);

      // single ALU write, then forwarded and drained
      step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
      idle(5'd3, 5'd3);
      idle(5'd3, 5'd0);

      // ALU and MDU to the same register: MDU is younger
      step(1'b0, 1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2, 5'd5, 5'd5);
      idle(5'd5, 5'd5);
      idle(5'd5, 5'd5);
      idle(5'd5, 5'd5);

      // writes to $zero are filtered
      step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      idle(5'd0, 5'd0);

      // fill to full, exercise back-pressure and pointer wrap
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b1, 5'(1 + 2 * (k % 4)), 32'(32'h100 + k), 1'b1,
              5'(2 + 2 * (k % 4)), 32'(32'h200 + k), 5'(1 + k), 5'(2 + k));
      end
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h777, 5'd7, 5'd1);
      step(1'b0, 1'b1, 5'd4, 32'h444, 1'b1, 5'd6, 32'h666, 5'd6, 5'd4);
      repeat (6) idle(5'd4, 5'd6);

      // reset with three writes pending
      step(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2);
      step(1'b0, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 5'd3, 5'd4);
      step(1'b1, 1'b1, 5'd9, 32'hA9, 1'b1, 5'd10, 32'hAA, 5'd3, 5'd2);
      idle(5'd3, 5'd4);
      idle(5'd9, 5'd10);

      // randomized traffic with occasional reset
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
              1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end

      repeat (DEPTH + 2) idle(5'd1, 5'd2);
      @(negedge clk);
      #4;
      chk("drain_complete", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
